// File: rtl/stopwatch_display.sv
// stopwatch_display
// MM:SS stopwatch core with a 4-digit multiplexed seven-segment driver.
// The tick inputs are one-clock enables. sel, adj and pause are debounced levels.
// In adjust mode, the selected field blinks on the 2 Hz phase.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   tick_1hz   count enable (RUN only)
//   tick_2hz   adjust increment / blink phase
//   tick_scan  digit scan advance
//   sel        adjust field: 0 = minutes, 1 = seconds
//   adj        adjust mode level
//   pause      pause level; each rising edge toggles the pause flag
//   seg        {g,f,e,d,c,b,a}, active-low, registered
//   an         digit enables, active-low one-hot, registered
//   minutes    current minutes count
//   seconds    current seconds count
//   paused     pause flag
//
// Mode decode (combinational, priority top-down)
//   mode    | meaning
//   ADJ_MIN | adj=1, sel=0: tick_2hz bumps minutes, no carry
//   ADJ_SEC | adj=1, sel=1: tick_2hz bumps seconds, no carry
//   HOLD    | adj=0, paused=1: counts frozen
//   RUN     | otherwise: tick_1hz advances MM:SS with carry
module stopwatch_display #(
  parameter int MAX_MIN  = 59,
  parameter int MAX_SEC  = 59,
  parameter int BLINK_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_scan,
  input  logic       sel,
  input  logic       adj,
  input  logic       pause,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       paused
);

  localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
  localparam logic [5:0] MAX_SEC_V = 6'(MAX_SEC);

  typedef enum logic [1:0] {
    ADJ_MIN = 2'd0,
    ADJ_SEC = 2'd1,
    HOLD    = 2'd2,
    RUN     = 2'd3
  } mode_t;

  mode_t      mode;
  logic       pause_q;
  logic       blink_phase;
  logic [1:0] digit;

  logic [5:0] min_nxt;
  logic [5:0] sec_nxt;
  logic       paused_nxt;
  logic       blink_nxt;
  logic [1:0] digit_nxt;
  logic [5:0] min_inc;
  logic [5:0] sec_inc;

  logic [3:0] dig_bcd;
  logic       blank;
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7f;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      minutes     <= 6'd0;
      seconds     <= 6'd0;
      paused      <= 1'b0;
      pause_q     <= 1'b0;
      blink_phase <= 1'b0;
      digit       <= 2'd0;
      an          <= 4'b1110;
      seg         <= 7'b1000000;
    end else begin
      minutes     <= min_nxt;
      seconds     <= sec_nxt;
      paused      <= paused_nxt;
      pause_q     <= pause;
      blink_phase <= blink_nxt;
      digit       <= digit_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
    end
  end

  // Mode decode and next-state logic
  always_comb begin
    if (adj && !sel)      mode = ADJ_MIN;
    else if (adj && sel)  mode = ADJ_SEC;
    else if (paused)      mode = HOLD;
    else                  mode = RUN;

    min_inc = (minutes == MAX_MIN_V) ? 6'd0 : minutes + 6'd1;
    sec_inc = (seconds == MAX_SEC_V) ? 6'd0 : seconds + 6'd1;

    min_nxt = minutes;
    sec_nxt = seconds;
    case (mode)
      RUN: begin
        if (tick_1hz) begin
          sec_nxt = sec_inc;
          if (seconds == MAX_SEC_V) min_nxt = min_inc;
        end
      end
      ADJ_MIN: if (tick_2hz) min_nxt = min_inc;
      ADJ_SEC: if (tick_2hz) sec_nxt = sec_inc;
      default: ;
    endcase

    // The pause toggle is tracked even in adjust mode. It only matters once adj drops.
    paused_nxt = paused ^ (pause & ~pause_q);

    if (adj) blink_nxt = blink_phase ^ tick_2hz;
    else     blink_nxt = 1'b0;

    digit_nxt = tick_scan ? digit + 2'd1 : digit;
  end

  // Display output logic, sampled from the current digit and counts
  always_comb begin
    case (digit)
      2'd0:    dig_bcd = 4'(seconds % 6'd10);
      2'd1:    dig_bcd = 4'(seconds / 6'd10);
      2'd2:    dig_bcd = 4'(minutes % 6'd10);
      default: dig_bcd = 4'(minutes / 6'd10);
    endcase

    // digit[1] set means a minutes digit. Blank the digits of the field under adjustment.
    blank = (BLINK_EN != 0) && adj && blink_phase && (sel ? !digit[1] : digit[1]);

    seg_nxt = blank ? 7'b1111111 : seg_code(dig_bcd);
    an_nxt  = ~(4'b0001 << digit);
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display.
// Stimulus pushes expected state into a queue, and a negedge monitor pops and compares.
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       tick_scan = 1'b0;
  logic       sel = 1'b0;
  logic       adj = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       paused;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic [5:0] m;
    logic [5:0] s;
    logic       p;
    bit         disp;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_display dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .tick_scan (tick_scan),
    .sel       (sel),
    .adj       (adj),
    .pause     (pause),
    .seg       (seg),
    .an        (an),
    .minutes   (minutes),
    .seconds   (seconds),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are registered, so they are stable at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      bit   bad;
      e = exp_q.pop_front();
      bad = (minutes !== e.m) || (seconds !== e.s) || (paused !== e.p) ||
            (e.disp && ((an !== e.an) || (seg !== e.seg)));
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got %0d:%0d p=%b an=%b seg=%b, want %0d:%0d p=%b an=%b seg=%b (disp=%0d)",
                 e.name, minutes, seconds, paused, an, seg, e.m, e.s, e.p, e.an, e.seg, e.disp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic tick(input bit h1, input bit h2, input bit sc);
    tick_1hz = h1; tick_2hz = h2; tick_scan = sc;
    cyc();
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_scan = 1'b0;
  endtask

  task automatic expect_cnt(input string name, input logic [5:0] m, input logic [5:0] s,
                            input logic p);
    exp_t e;
    e.name = name; e.m = m; e.s = s; e.p = p; e.disp = 1'b0; e.an = 4'b0; e.seg = 7'b0;
    exp_q.push_back(e);
  endtask

  task automatic expect_all(input string name, input logic [5:0] m, input logic [5:0] s,
                            input logic p, input logic [3:0] a, input logic [6:0] sg);
    exp_t e;
    e.name = name; e.m = m; e.s = s; e.p = p; e.disp = 1'b1; e.an = a; e.seg = sg;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    idle(2);
    expect_all("reset", 0, 0, 0, 4'b1110, 7'h40);
    rst = 1'b0;

    // Count 60 seconds, then scan all four digits
    repeat (60) tick(1, 0, 0);
    expect_cnt("count60", 1, 0, 0);
    tick(0, 0, 1);
    expect_all("scan_lag", 1, 0, 0, 4'b1110, 7'h40);
    idle(1);
    expect_all("scan_d1", 1, 0, 0, 4'b1101, 7'h40);
    tick(0, 0, 1); idle(1);
    expect_all("scan_d2", 1, 0, 0, 4'b1011, 7'h79);
    tick(0, 0, 1); idle(1);
    expect_all("scan_d3", 1, 0, 0, 4'b0111, 7'h40);
    tick(0, 0, 1);

    // Preload 59:59, then wrap in RUN
    adj = 1'b1; sel = 1'b0;
    repeat (58) tick(0, 1, 0);
    sel = 1'b1;
    repeat (59) tick(0, 1, 0);
    expect_cnt("preload", 59, 59, 0);
    adj = 1'b0; sel = 1'b0;
    tick(1, 0, 0);
    idle(1);
    expect_all("wrap", 0, 0, 0, 4'b1110, 7'h40);
    tick(0, 1, 0);
    expect_cnt("run_ign_2hz", 0, 0, 0);

    // Pause / hold / resume
    pause = 1'b1; idle(1);
    expect_cnt("pause_on", 0, 0, 1);
    repeat (5) tick(1, 0, 0);
    tick(0, 1, 0);
    expect_cnt("hold", 0, 0, 1);
    pause = 1'b0; idle(1);
    pause = 1'b1; idle(1);
    expect_cnt("resume", 0, 0, 0);
    tick(1, 0, 0);
    expect_cnt("run_after", 0, 1, 0);
    pause = 1'b0; idle(1);
    pause = 1'b1; tick(1, 0, 0);
    expect_cnt("pause_tick", 0, 2, 1);
    tick(1, 0, 0);
    expect_cnt("held", 0, 2, 1);
    pause = 1'b0; idle(1);
    pause = 1'b1; idle(1);
    expect_cnt("resume2", 0, 2, 0);

    // Seconds adjust across the wrap. There is no carry into minutes.
    adj = 1'b1; sel = 1'b1;
    repeat (56) tick(0, 1, 0);
    expect_cnt("adj_58", 0, 58, 0);
    tick(0, 1, 0);
    expect_cnt("adj_59", 0, 59, 0);
    tick(0, 1, 0);
    expect_cnt("adj_0", 0, 0, 0);
    tick(0, 1, 0);
    expect_cnt("adj_1", 0, 1, 0);
    tick(1, 1, 0);
    expect_cnt("adj_both", 0, 2, 0);
    tick(1, 0, 0);
    expect_cnt("adj_ign_1hz", 0, 2, 0);

    // Minutes adjust on an odd blink phase blanks the minute digits
    sel = 1'b0;
    tick(0, 1, 0);
    idle(1);
    expect_all("blink_d0", 1, 2, 0, 4'b1110, 7'h24);
    tick(0, 0, 1); idle(1);
    expect_all("blink_d1", 1, 2, 0, 4'b1101, 7'h40);
    tick(0, 0, 1); idle(1);
    expect_all("blink_d2", 1, 2, 0, 4'b1011, 7'h7f);
    tick(0, 0, 1); idle(1);
    expect_all("blink_d3", 1, 2, 0, 4'b0111, 7'h7f);
    tick(0, 0, 1); idle(1);
    expect_all("blink_wrap", 1, 2, 0, 4'b1110, 7'h24);
    tick(0, 1, 0);
    tick(0, 0, 1); tick(0, 0, 1); idle(1);
    expect_all("blink_even", 2, 2, 0, 4'b1011, 7'h24);

    // Reset mid-count at 12:34 while held
    repeat (10) tick(0, 1, 0);
    sel = 1'b1;
    repeat (32) tick(0, 1, 0);
    adj = 1'b0; sel = 1'b0;
    pause = 1'b0; idle(1);
    pause = 1'b1; idle(1);
    expect_cnt("hold_1234", 12, 34, 1);
    rst = 1'b1; pause = 1'b0;
    idle(1);
    expect_all("mid_reset", 0, 0, 0, 4'b1110, 7'h40);
    rst = 1'b0;
    idle(1);
    expect_cnt("after_reset", 0, 0, 0);

    // Drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
